// File: rtl/l2_i_refill_responder_if.sv
// L1-refill / memory handshake bundle for the L2 instruction refill responder.
// The master drives requests and memory responses; the slave is the responder.
interface l2_i_refill_responder_if #(
  parameter int L1_TNUM = 21,
  parameter int L1_INUM = 26 - L1_TNUM,
  parameter int L2_INUM = 8
);
  logic               read_L1_L2;
  logic [L1_TNUM-1:0] tag_L1_L2;
  logic [L1_INUM-1:0] index_L1_L2;
  logic               flush;
  logic               ready_MEM_L2;
  logic               ready_L2_L1;
  logic               read_L2_MEM;
  logic [25:0]        address_L2_MEM;
  logic               refill;
  logic               way;
  logic [L2_INUM-1:0] index_L2;
  logic               stall;

  modport master (
    output read_L1_L2, tag_L1_L2, index_L1_L2, flush, ready_MEM_L2,
    input  ready_L2_L1, read_L2_MEM, address_L2_MEM, refill, way, index_L2, stall
  );

  modport slave (
    input  read_L1_L2, tag_L1_L2, index_L1_L2, flush, ready_MEM_L2,
    output ready_L2_L1, read_L2_MEM, address_L2_MEM, refill, way, index_L2, stall
  );
endinterface

// File: rtl/l2_i_refill_responder.sv
// 2-way L2 tag/valid/LRU controller answering L1 I refills: hit -> ready 2 cycles after accept,
// miss -> memory read held until ready_MEM_L2, refill next cycle, ready the cycle after.
module l2_i_refill_responder #(
  parameter int L1_TNUM = 21,
  parameter int L1_INUM = 26 - L1_TNUM,
  parameter int L2_INUM = 8,
  parameter int L2_TNUM = 26 - L2_INUM
) (
  input  logic                    clk,
  input  logic                    rst,
  l2_i_refill_responder_if.slave  bus
);
  localparam int NSETS = 1 << L2_INUM;

  typedef enum logic [2:0] {IDLE, COMPARE, MEM_REQ, REFILL, RESPOND, RELEASE} state_t;

  state_t state, state_nxt;

  logic [25:0]        blk_addr;
  logic [L2_TNUM-1:0] tag_arr [NSETS][2];
  logic [1:0]         valid_arr [NSETS];
  logic [NSETS-1:0]   lru_arr;

  logic               way_q, way_c;
  logic [L2_INUM-1:0] index_q, index_c;

  logic [L2_INUM-1:0] set_idx;
  logic [L2_TNUM-1:0] blk_tag;
  logic [1:0]         cur_valid;
  logic               hit0, hit1, hit, hit_way, victim;

  assign set_idx   = blk_addr[L2_INUM-1:0];
  assign blk_tag   = blk_addr[25:L2_INUM];
  assign cur_valid = valid_arr[set_idx];
  assign hit0      = cur_valid[0] && (tag_arr[set_idx][0] == blk_tag);
  assign hit1      = cur_valid[1] && (tag_arr[set_idx][1] == blk_tag);
  assign hit       = hit0 || hit1;
  assign hit_way   = ~hit0;
  // Fill invalid ways in order before evicting the LRU way.
  assign victim    = !cur_valid[0] ? 1'b0 : (!cur_valid[1] ? 1'b1 : lru_arr[set_idx]);

  always_comb begin
    state_nxt = state;
    way_c     = way_q;
    index_c   = index_q;
    case (state)
      IDLE:    if (!bus.flush && bus.read_L1_L2) state_nxt = COMPARE;
      COMPARE: begin
        index_c = set_idx;
        if (hit) begin
          way_c     = hit_way;
          state_nxt = RESPOND;
        end else begin
          state_nxt = MEM_REQ;
        end
      end
      MEM_REQ: if (bus.ready_MEM_L2) state_nxt = REFILL;
      REFILL: begin
        index_c   = set_idx;
        way_c     = victim;
        state_nxt = RESPOND;
      end
      RESPOND: begin
        index_c   = set_idx;
        state_nxt = RELEASE;
      end
      RELEASE: if (!bus.read_L1_L2) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      blk_addr <= '0;
      way_q    <= 1'b0;
      index_q  <= '0;
      lru_arr  <= '0;
      for (int i = 0; i < NSETS; i++) valid_arr[i] <= 2'b00;
    end else begin
      state   <= state_nxt;
      way_q   <= way_c;
      index_q <= index_c;
      if (state == IDLE && bus.flush) begin
        lru_arr <= '0;
        for (int i = 0; i < NSETS; i++) valid_arr[i] <= 2'b00;
      end else if (state == IDLE && bus.read_L1_L2) begin
        blk_addr <= {bus.tag_L1_L2, bus.index_L1_L2};
      end
      if (state == COMPARE && hit) lru_arr[set_idx] <= ~hit_way;
      if (state == REFILL) begin
        valid_arr[set_idx][victim] <= 1'b1;
        lru_arr[set_idx]           <= ~victim;
      end
    end
  end

  // Tags carry no reset; valid bits gate every compare.
  always_ff @(posedge clk) begin
    if (!rst && state == REFILL) tag_arr[set_idx][victim] <= blk_tag;
  end

  assign bus.ready_L2_L1    = (state == RESPOND);
  assign bus.read_L2_MEM    = (state == MEM_REQ);
  assign bus.address_L2_MEM = blk_addr;
  assign bus.refill         = (state == REFILL);
  assign bus.way            = way_c;
  assign bus.index_L2       = index_c;
  assign bus.stall          = (state != IDLE);
endmodule

// File: tb/tb_l2_i_refill_responder.sv
// Directed bench for l2_i_refill_responder: hit/miss timing, victim choice, hold, flush and reset.
module tb_l2_i_refill_responder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  l2_i_refill_responder_if bus ();
  l2_i_refill_responder dut (.clk(clk), .rst(rst), .bus(bus));

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_stall"},   32'(bus.stall), 0);
    check({tag, "_ready"},   32'(bus.ready_L2_L1), 0);
    check({tag, "_rdmem"},   32'(bus.read_L2_MEM), 0);
    check({tag, "_refill"},  32'(bus.refill), 0);
    check({tag, "_way"},     32'(bus.way), 0);
    check({tag, "_index"},   32'(bus.index_L2), 0);
    check({tag, "_addr"},    32'(bus.address_L2_MEM), 0);
  endtask

  // One L1 request: drive, follow the expected hit or miss timeline, then release.
  task automatic req(input logic [20:0] t, input logic [4:0] ix, input bit exp_hit,
                     input bit exp_way, input int hold, input bit flush_mid);
    logic [25:0] b;
    b = {t, ix};
    @(negedge clk);
    bus.read_L1_L2  = 1'b1;
    bus.tag_L1_L2   = t;
    bus.index_L1_L2 = ix;
    @(negedge clk);
    check("cmp_no_ready", 32'(bus.ready_L2_L1), 0);
    check("cmp_stall",    32'(bus.stall), 1);
    @(negedge clk);
    if (exp_hit) begin
      check("hit_ready",     32'(bus.ready_L2_L1), 1);
      check("hit_way",       32'(bus.way), 32'(exp_way));
      check("hit_index",     32'(bus.index_L2), 32'(b[7:0]));
      check("hit_no_rdmem",  32'(bus.read_L2_MEM), 0);
      check("hit_no_refill", 32'(bus.refill), 0);
    end else begin
      check("miss_rdmem",    32'(bus.read_L2_MEM), 1);
      check("miss_addr",     32'(bus.address_L2_MEM), 32'(b));
      check("miss_no_ready", 32'(bus.ready_L2_L1), 0);
      if (flush_mid) bus.flush = 1'b1;
      @(negedge clk);
      check("mem_hold_rdmem", 32'(bus.read_L2_MEM), 1);
      check("mem_hold_addr",  32'(bus.address_L2_MEM), 32'(b));
      bus.flush        = 1'b0;
      bus.ready_MEM_L2 = 1'b1;
      @(negedge clk);
      bus.ready_MEM_L2 = 1'b0;
      check("refill_en",    32'(bus.refill), 1);
      check("refill_way",   32'(bus.way), 32'(exp_way));
      check("refill_index", 32'(bus.index_L2), 32'(b[7:0]));
      check("refill_rdmem", 32'(bus.read_L2_MEM), 0);
      @(negedge clk);
      check("resp_ready",   32'(bus.ready_L2_L1), 1);
      check("resp_way",     32'(bus.way), 32'(exp_way));
      check("resp_index",   32'(bus.index_L2), 32'(b[7:0]));
      check("resp_refill",  32'(bus.refill), 0);
    end
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("hold_no_ready", 32'(bus.ready_L2_L1), 0);
      check("hold_stall",    32'(bus.stall), 1);
      check("hold_no_rdmem", 32'(bus.read_L2_MEM), 0);
      check("hold_way",      32'(bus.way), 32'(exp_way));
    end
    bus.read_L1_L2 = 1'b0;
    @(negedge clk);
    check("rel_no_ready", 32'(bus.ready_L2_L1), 0);
    @(negedge clk);
    check("idle_stall", 32'(bus.stall), 0);
    check("idle_way",   32'(bus.way), 32'(exp_way));
  endtask

  initial begin
    rst              = 1'b1;
    bus.read_L1_L2   = 1'b0;
    bus.tag_L1_L2    = '0;
    bus.index_L1_L2  = '0;
    bus.flush        = 1'b0;
    bus.ready_MEM_L2 = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Set 0x23: cold miss, hit, fill way 1, LRU-driven evictions.
    req(21'h1,  5'h03, 1'b0, 1'b0, 0, 1'b0);  // B=0x023 -> way0
    req(21'h1,  5'h03, 1'b1, 1'b0, 0, 1'b0);  // hit way0
    req(21'h9,  5'h03, 1'b0, 1'b1, 0, 1'b0);  // B=0x123 -> invalid way1
    req(21'h1,  5'h03, 1'b1, 1'b0, 0, 1'b0);  // touch way0, LRU=1
    req(21'h11, 5'h03, 1'b0, 1'b1, 0, 1'b0);  // B=0x223 evicts 0x123 in way1
    req(21'h9,  5'h03, 1'b0, 1'b0, 0, 1'b0);  // 0x123 misses, LRU=0 -> way0
    req(21'h11, 5'h03, 1'b1, 1'b1, 5, 1'b0);  // held request: one ready only

    // Three sets populated, then a one-cycle flush in IDLE.
    req(21'h2, 5'h05, 1'b0, 1'b0, 0, 1'b0);   // B=0x045
    req(21'h3, 5'h06, 1'b0, 1'b0, 0, 1'b0);   // B=0x066
    req(21'h2, 5'h05, 1'b1, 1'b0, 0, 1'b0);
    @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_no_stall", 32'(bus.stall), 0);
    req(21'h9, 5'h03, 1'b0, 1'b0, 0, 1'b0);
    req(21'h2, 5'h05, 1'b0, 1'b0, 0, 1'b0);
    req(21'h3, 5'h06, 1'b0, 1'b0, 0, 1'b1);   // flush during MEM_REQ ignored
    req(21'h3, 5'h06, 1'b1, 1'b0, 0, 1'b0);
    req(21'h2, 5'h05, 1'b1, 1'b0, 0, 1'b0);

    // Reset while waiting on memory, then a stale memory response.
    @(negedge clk);
    bus.read_L1_L2  = 1'b1;
    bus.tag_L1_L2   = 21'h4;
    bus.index_L1_L2 = 5'h07;
    repeat (2) @(negedge clk);
    check("rstmid_rdmem", 32'(bus.read_L2_MEM), 1);
    rst            = 1'b1;
    bus.read_L1_L2 = 1'b0;
    @(negedge clk);
    check_all_zero("rstmid");
    rst              = 1'b0;
    bus.ready_MEM_L2 = 1'b1;
    @(negedge clk);
    bus.ready_MEM_L2 = 1'b0;
    check("stale_no_refill", 32'(bus.refill), 0);
    check("stale_no_stall",  32'(bus.stall), 0);
    @(negedge clk);
    check("stale_no_ready",  32'(bus.ready_L2_L1), 0);
    check("stale_idle",      32'(bus.stall), 0);
    req(21'h2, 5'h05, 1'b0, 1'b0, 0, 1'b0);   // previously valid block misses after reset
    req(21'h4, 5'h07, 1'b0, 1'b0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/l2_i_refill_responder.md
Name: l2_i_refill_responder

Overview:
- L2-side responder for L1 instruction-cache refill requests; the other end of the read_L1_L2 / ready_L2_L1 handshake driven by the L1 I controller.
- Holds the L2 tag/valid/LRU state for a 2-way set-associative L2 (controller only; data arrays are external).
- Answers hits directly. On a miss, fetches the block from memory through a read/ready handshake, refills, then answers.

Parameters:
- L1_TNUM, 21, L1 tag bits received from L1.
- L1_INUM, 26 - L1_TNUM, L1 index bits received from L1.
- L2_INUM, 8, L2 set-index bits (256 sets).
- L2_TNUM, 26 - L2_INUM, L2 tag bits.

Ports:
- clk, input, 1, the single clock.
- rst, input, 1, reset; synchronous, active-high.
- read_L1_L2, input, 1, L1 refill request; held high until ready_L2_L1 is seen.
- tag_L1_L2, input, L1_TNUM, requested block tag.
- index_L1_L2, input, L1_INUM, requested block index.
- flush, input, 1, invalidate all L2 entries.
- ready_MEM_L2, input, 1, memory returned the requested block (1-cycle pulse).
- ready_L2_L1, output, 1, block available to L1 (1-cycle pulse).
- read_L2_MEM, output, 1, memory read request.
- address_L2_MEM, output, 26, block address {tag, index} sent to memory.
- refill, output, 1, write enable for the L2 data array (1 cycle).
- way, output, 1, way being read (hit) or refilled (miss).
- index_L2, output, L2_INUM, set index for the L2 data array.
- stall, output, 1, high whenever state is not IDLE.

Behaviour:
- Block address B = {tag_L1_L2, index_L1_L2} (26 bits). L2 set = B[L2_INUM-1:0]. L2 tag = B[25:L2_INUM].
- Per set: valid[1:0], tag[1:0], one LRU bit. The LRU bit names the least-recently-used way.
- FSM states: IDLE, COMPARE, MEM_REQ, REFILL, RESPOND, RELEASE.
- IDLE:
  - flush=1: clear all valid and LRU bits this cycle; stay in IDLE. Flush has priority over read.
  - else read_L1_L2=1: latch B, go to COMPARE.
- Flush outside IDLE is ignored. The source must hold flush until stall=0.
- COMPARE:
  - Hit: way = hit way; LRU := ~hit way; go to RESPOND.
  - Miss: go to MEM_REQ.
  - Both ways valid and matching cannot occur; if it does, way 0 wins.
- MEM_REQ:
  - read_L2_MEM=1 and address_L2_MEM=B, held stable until ready_MEM_L2=1.
  - On ready_MEM_L2=1: go to REFILL.
  - ready_MEM_L2 in any other state is ignored.
- Victim selection: invalid way 0 first, else invalid way 1, else the LRU way.
- REFILL (1 cycle):
  - refill=1, way=victim, index_L2=set.
  - At the end of the cycle: tag[victim] := L2 tag, valid[victim] := 1, LRU := ~victim.
  - Go to RESPOND.
- RESPOND (1 cycle): ready_L2_L1=1, way and index_L2 valid; go to RELEASE.
- RELEASE: wait until read_L1_L2=0, then go to IDLE. A request still held after ready_L2_L1 is never re-accepted.
- Latency (request first sampled high in IDLE at cycle N):
  - Hit: ready_L2_L1 high in cycle N+2.
  - Miss: read_L2_MEM high from cycle N+2. If ready_MEM_L2 arrives in cycle M: refill in M+1, ready_L2_L1 in M+2.
- index_L2 and way hold their last values outside COMPARE, REFILL and RESPOND.
- Reset (any state, including mid-MEM_REQ): state := IDLE, all valid and LRU bits := 0, all outputs := 0.
- After reset, an outstanding memory response is ignored; the memory side must be reset in the same cycle.
- Tag array contents are don't-care at reset; valid bits gate all compares.

Test Plan:
- Reset, then cold miss tag=21'h1, index=5'h03 (B=26'h23, set 8'h23) -> read_L2_MEM=1 with address_L2_MEM=26'h23. ready_MEM_L2 at cycle M -> refill=1, way=0 at M+1; ready_L2_L1=1 at M+2.
- Repeat the same request after RELEASE -> hit: ready_L2_L1 exactly 2 cycles after acceptance, way=0, read_L2_MEM stays 0, refill stays 0.
- Fill set 8'h23 with tag=21'h9 (B=26'h123) then tag=21'h11 (B=26'h223):
  - B=26'h123 -> refill way=1.
  - Re-read B=26'h23 (LRU now points to way 1).
  - B=26'h223 -> refill way=1, evicting 26'h123; a following read of 26'h123 misses.
- Hold read_L1_L2=1 for 5 cycles after ready_L2_L1 -> exactly one ready pulse, stall=1 until read_L1_L2 drops, no new COMPARE.
- Fill 3 sets, assert flush in IDLE for 1 cycle -> re-reading all 3 blocks misses (read_L2_MEM=1 each time). Flush asserted during MEM_REQ has no effect.
- Assert rst in MEM_REQ, then pulse ready_MEM_L2 -> all outputs 0, state IDLE, no refill. The next request to the same block misses.
